// File: rtl/iu_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iu_mult_pkg
// Description : Shared definitions for the IU pipelined multiplier.
//               - Op encodings (MUL / MULH / MULHSU / MULHU)
//               - Stage control struct
//               - sel_result(): pick low or high result half from a product
// Revision    : 1.0 - initial release
// ============================================================================
package iu_mult_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  // Widest operand supported by sel_result(); products are zero-extended
  // into this container so one function serves every WIDTH.
  localparam int unsigned MAX_W      = 64;
  localparam int unsigned MAX_PROD_W = 2 * MAX_W + 2;

  // Per-stage control: valid flag plus the low/high select carried with the
  // product. The tag and product fields are WIDTH/TAG_W dependent and are
  // packed alongside this struct in the top-level payload.
  typedef struct packed {
    logic vld;
    logic op_hi;
  } stage_ctrl_t;

  // Low half for MUL, bits [2*width-1:width] for the high variants.
  // Caller truncates the return value to its own width.
  function automatic logic [MAX_W-1:0] sel_result(
    input logic [MAX_PROD_W-1:0] prod,
    input logic                  op_hi,
    input int unsigned           width
  );
    return op_hi ? MAX_W'(prod >> width) : MAX_W'(prod);
  endfunction

endpackage : iu_mult_pkg
`default_nettype wire

// File: rtl/iu_mult_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : iu_mult_pipe_stage
// Description : One register slice of the multiplier pipe.
//               Valid is cleared by flush regardless of enable; payload only
//               loads on enable (bubbles may leave stale payload behind).
// Ports       : clk_i    - clock
//               rst_ni   - async active-low reset
//               en_i     - shift enable (pipe advance)
//               flush_i  - clear valid at next edge
//               vld_i    - upstream valid
//               pay_i    - upstream payload
//               vld_o    - registered valid
//               pay_o    - registered payload
// Revision    : 1.0 - initial release
// ============================================================================
module iu_mult_pipe_stage
  import iu_mult_pkg::*;
#(
  parameter int unsigned PAY_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             vld_i,
  input  logic [PAY_W-1:0] pay_i,
  output logic             vld_o,
  output logic [PAY_W-1:0] pay_o
);

  logic             vld_q;
  logic [PAY_W-1:0] pay_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= 1'b0;
      pay_q <= '0;
    end else begin
      if (flush_i) begin
        vld_q <= 1'b0;
      end else if (en_i) begin
        vld_q <= vld_i;
      end
      if (en_i) begin
        pay_q <= pay_i;
      end
    end
  end

  assign vld_o = vld_q;
  assign pay_o = pay_q;

endmodule : iu_mult_pipe_stage
`default_nettype wire

// File: rtl/iu_mult_pipe_fpga.sv
`default_nettype none
// ============================================================================
// Module      : iu_mult_pipe_fpga
// Description : Pipelined integer multiplier (MUL/MULH/MULHSU/MULHU) with
//               valid/ready handshake, flush and tag passthrough. The product
//               is formed combinationally ahead of stage 0 and then carried
//               through STAGES register slices so the FPGA tools can retime
//               it into the DSP pipeline registers.
// Ports       : forever_cpuclk - clock
//               cpurst_b       - async active-low reset
//               mult_in_*      - issue side (vld/rdy/op/src0/src1/tag)
//               mult_flush     - kill all in-flight ops
//               mult_out_*     - writeback side (vld/rdy/data/tag)
//               mult_busy      - any stage holds a valid op
// Revision    : 1.0 - initial release
// ============================================================================
module iu_mult_pipe_fpga
  import iu_mult_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,  // must not exceed MAX_W
  parameter int unsigned STAGES = 3,   // latency in cycles, >= 1
  parameter int unsigned TAG_W  = 5
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             mult_in_vld,
  output logic             mult_in_rdy,
  input  logic [1:0]       mult_in_op,
  input  logic [WIDTH-1:0] mult_in_src0,
  input  logic [WIDTH-1:0] mult_in_src1,
  input  logic [TAG_W-1:0] mult_in_tag,
  input  logic             mult_flush,
  output logic             mult_out_vld,
  input  logic             mult_out_rdy,
  output logic [WIDTH-1:0] mult_out_data,
  output logic [TAG_W-1:0] mult_out_tag,
  output logic             mult_busy
);

  localparam int unsigned PROD_W = 2 * WIDTH + 2;
  localparam int unsigned PAY_W  = 1 + TAG_W + PROD_W;

  typedef struct packed {
    logic             op_hi;
    logic [TAG_W-1:0] tag;
    logic [PROD_W-1:0] prod;
  } payload_t;

  logic                     w_src0_sgn;
  logic                     w_src1_sgn;
  logic [WIDTH:0]           w_a;
  logic [WIDTH:0]           w_b;
  logic signed [PROD_W-1:0] w_a_sx;
  logic signed [PROD_W-1:0] w_b_sx;
  logic signed [PROD_W-1:0] w_prod;
  logic                     w_advance;
  logic                     w_accept;
  payload_t                 w_in_pay;
  payload_t                 w_out_pay;
  logic [STAGES:0]          w_vld;
  logic [PAY_W-1:0]         w_pay [STAGES+1];

  // Operand extension to WIDTH+1 so one signed multiplier covers all modes.
  assign w_src0_sgn = (mult_in_op == OP_MULH) || (mult_in_op == OP_MULHSU);
  assign w_src1_sgn = (mult_in_op == OP_MULH);
  assign w_a        = {w_src0_sgn & mult_in_src0[WIDTH-1], mult_in_src0};
  assign w_b        = {w_src1_sgn & mult_in_src1[WIDTH-1], mult_in_src1};

  // Operands sign-extended to full product width so the multiply is
  // self-determined at PROD_W bits (result exact modulo 2^PROD_W).
  assign w_a_sx = $signed({{(WIDTH+1){w_a[WIDTH]}}, w_a});
  assign w_b_sx = $signed({{(WIDTH+1){w_b[WIDTH]}}, w_b});
  assign w_prod = w_a_sx * w_b_sx;

  always_comb begin
    w_in_pay       = '0;
    w_in_pay.op_hi = (mult_in_op != OP_MUL);
    w_in_pay.tag   = mult_in_tag;
    w_in_pay.prod  = w_prod;
  end

  // Whole pipe moves together; it stalls only when a result sits unconsumed.
  assign w_advance   = ~mult_out_vld | mult_out_rdy;
  assign mult_in_rdy = w_advance;
  // An op offered alongside a flush is discarded rather than entering the pipe.
  assign w_accept    = mult_in_vld & w_advance & ~mult_flush;

  assign w_vld[0] = w_accept;
  assign w_pay[0] = w_in_pay;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    iu_mult_pipe_stage #(
      .PAY_W (PAY_W)
    ) u_stage (
      .clk_i   (forever_cpuclk),
      .rst_ni  (cpurst_b),
      .en_i    (w_advance),
      .flush_i (mult_flush),
      .vld_i   (w_vld[i]),
      .pay_i   (w_pay[i]),
      .vld_o   (w_vld[i+1]),
      .pay_o   (w_pay[i+1])
    );
  end

  assign w_out_pay     = w_pay[STAGES];
  assign mult_out_vld  = w_vld[STAGES];
  assign mult_out_tag  = w_out_pay.tag;
  assign mult_out_data = WIDTH'(sel_result(MAX_PROD_W'(w_out_pay.prod),
                                           w_out_pay.op_hi, WIDTH));
  assign mult_busy     = |w_vld[STAGES:1];

endmodule : iu_mult_pipe_fpga
`default_nettype wire

// File: tb/tb_iu_mult_pipe_fpga.sv
`default_nettype none
// ============================================================================
// Module      : tb_iu_mult_pipe_fpga
// Description : Directed self-checking bench for iu_mult_pipe_fpga
//               (WIDTH=32, STAGES=3, TAG_W=5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iu_mult_pipe_fpga;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 3;
  localparam int unsigned TAG_W  = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_vld;
  logic             in_rdy;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] src0;
  logic [WIDTH-1:0] src1;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  iu_mult_pipe_fpga #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .TAG_W  (TAG_W)
  ) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .mult_in_vld    (in_vld),
    .mult_in_rdy    (in_rdy),
    .mult_in_op     (in_op),
    .mult_in_src0   (src0),
    .mult_in_src1   (src1),
    .mult_in_tag    (in_tag),
    .mult_flush     (flush),
    .mult_out_vld   (out_vld),
    .mult_out_rdy   (out_rdy),
    .mult_out_data  (out_data),
    .mult_out_tag   (out_tag),
    .mult_busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t);
    in_vld = 1'b1;
    in_op  = op;
    src0   = a;
    src1   = b;
    in_tag = t;
  endtask

  task automatic idle_in();
    in_vld = 1'b0;
    in_op  = 2'b00;
    src0   = '0;
    src1   = '0;
    in_tag = '0;
  endtask

  task automatic test_reset();
    idle_in();
    flush   = 1'b0;
    out_rdy = 1'b1;
    rst_n   = 1'b0;
    tick();
    tick();
    n_checks++;
    if (out_vld !== 1'b0) $display("FAIL reset_out_vld: got %b want 0", out_vld);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if (out_data !== 32'h0 || out_tag !== 5'd0)
      $display("FAIL reset_data_tag: got %h/%0d want 0/0", out_data, out_tag);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (in_rdy !== 1'b1) $display("FAIL reset_in_rdy: got %b want 1", in_rdy);
    else n_pass++;
  endtask

  // Single ops in each mode; latency and result checked per op.
  task automatic test_ops();
    logic [1:0]  ops  [5];
    logic [31:0] as   [5];
    logic [31:0] bs   [5];
    logic [31:0] exps [5];
    ops[0] = 2'b00; as[0] = 32'hFFFFFFFF; bs[0] = 32'hFFFFFFFF; exps[0] = 32'h00000001;
    ops[1] = 2'b11; as[1] = 32'hFFFFFFFF; bs[1] = 32'hFFFFFFFF; exps[1] = 32'hFFFFFFFE;
    ops[2] = 2'b01; as[2] = 32'hFFFFFFFF; bs[2] = 32'hFFFFFFFF; exps[2] = 32'h00000000;
    ops[3] = 2'b10; as[3] = 32'hFFFFFFFF; bs[3] = 32'hFFFFFFFF; exps[3] = 32'hFFFFFFFF;
    ops[4] = 2'b01; as[4] = 32'h80000000; bs[4] = 32'h80000000; exps[4] = 32'h40000000;
    out_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(ops[k], as[k], bs[k], 5'(k + 10));
      tick();
      idle_in();
      n_checks++;
      if (out_vld !== 1'b0 || busy !== 1'b1)
        $display("FAIL op%0d_lat1: out_vld=%b busy=%b want 0/1", k, out_vld, busy);
      else n_pass++;
      tick();
      n_checks++;
      if (out_vld !== 1'b0) $display("FAIL op%0d_lat2: out_vld=%b want 0", k, out_vld);
      else n_pass++;
      tick();
      n_checks++;
      if (out_vld !== 1'b1 || out_data !== exps[k] || out_tag !== 5'(k + 10))
        $display("FAIL op%0d_result: vld=%b data=%h tag=%0d want 1/%h/%0d",
                 k, out_vld, out_data, out_tag, exps[k], k + 10);
      else n_pass++;
      tick();
      n_checks++;
      if (out_vld !== 1'b0 || busy !== 1'b0)
        $display("FAIL op%0d_drain: out_vld=%b busy=%b want 0/0", k, out_vld, busy);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'd6; exp_d[1] = 32'd20; exp_d[2] = 32'd56;
    out_rdy = 1'b1;
    drive(2'b00, 32'd2, 32'd3, 5'd1);
    #1;
    n_checks++;
    if (in_rdy !== 1'b1) $display("FAIL b2b_rdy0: got %b want 1", in_rdy); else n_pass++;
    tick();
    drive(2'b00, 32'd4, 32'd5, 5'd2);
    #1;
    n_checks++;
    if (in_rdy !== 1'b1) $display("FAIL b2b_rdy1: got %b want 1", in_rdy); else n_pass++;
    tick();
    drive(2'b00, 32'd7, 32'd8, 5'd3);
    #1;
    n_checks++;
    if (in_rdy !== 1'b1) $display("FAIL b2b_rdy2: got %b want 1", in_rdy); else n_pass++;
    tick();
    idle_in();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_vld !== 1'b1 || out_data !== exp_d[k] || out_tag !== 5'(k + 1))
        $display("FAIL b2b_out%0d: vld=%b data=%0d tag=%0d want 1/%0d/%0d",
                 k, out_vld, out_data, out_tag, exp_d[k], k + 1);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (out_vld !== 1'b0) $display("FAIL b2b_end: out_vld=%b want 0", out_vld); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'd100; exp_d[1] = 32'd121; exp_d[2] = 32'd144;
    out_rdy = 1'b0;
    drive(2'b00, 32'd9, 32'd9, 5'd4);
    tick();
    drive(2'b00, 32'd10, 32'd10, 5'd5);
    tick();
    drive(2'b00, 32'd11, 32'd11, 5'd6);
    tick();
    // Pipe full, head result unconsumed; next op waits at the input.
    drive(2'b00, 32'd12, 32'd12, 5'd7);
    #1;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (in_rdy !== 1'b0 || out_vld !== 1'b1 || out_data !== 32'd81 || out_tag !== 5'd4)
        $display("FAIL bp_hold%0d: rdy=%b vld=%b data=%0d tag=%0d want 0/1/81/4",
                 c, in_rdy, out_vld, out_data, out_tag);
      else n_pass++;
      if (c < 2) tick();
    end
    out_rdy = 1'b1;
    #1;
    n_checks++;
    if (in_rdy !== 1'b1) $display("FAIL bp_release_rdy: got %b want 1", in_rdy); else n_pass++;
    tick();
    idle_in();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_vld !== 1'b1 || out_data !== exp_d[k] || out_tag !== 5'(k + 5))
        $display("FAIL bp_out%0d: vld=%b data=%0d tag=%0d want 1/%0d/%0d",
                 k, out_vld, out_data, out_tag, exp_d[k], k + 5);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (out_vld !== 1'b0 || busy !== 1'b0)
      $display("FAIL bp_end: vld=%b busy=%b want 0/0", out_vld, busy);
    else n_pass++;
  endtask

  task automatic test_flush();
    int seen;
    out_rdy = 1'b1;
    drive(2'b00, 32'd3, 32'd3, 5'd8);
    tick();
    drive(2'b00, 32'd4, 32'd4, 5'd9);
    tick();
    drive(2'b00, 32'd5, 32'd5, 5'd10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_in();
    n_checks++;
    if (busy !== 1'b0 || out_vld !== 1'b0)
      $display("FAIL flush_clear: busy=%b vld=%b want 0/0", busy, out_vld);
    else n_pass++;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_vld === 1'b1) seen++;
      tick();
    end
    n_checks++;
    if (seen != 0) $display("FAIL flush_no_result: got %0d results want 0", seen);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    out_rdy = 1'b0;
    drive(2'b00, 32'd6, 32'd7, 5'd12);
    tick();
    idle_in();
    tick();
    tick();
    n_checks++;
    if (out_vld !== 1'b1 || out_data !== 32'd42)
      $display("FAIL arst_pre: vld=%b data=%0d want 1/42", out_vld, out_data);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_vld !== 1'b0 || busy !== 1'b0)
      $display("FAIL arst_immediate: vld=%b busy=%b want 0/0", out_vld, busy);
    else n_pass++;
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    tick();
    drive(2'b00, 32'd3, 32'd5, 5'd11);
    tick();
    idle_in();
    tick();
    n_checks++;
    if (out_vld !== 1'b0) $display("FAIL arst_lat2: vld=%b want 0", out_vld); else n_pass++;
    tick();
    n_checks++;
    if (out_vld !== 1'b1 || out_data !== 32'd15 || out_tag !== 5'd11)
      $display("FAIL arst_after: vld=%b data=%0d tag=%0d want 1/15/11",
               out_vld, out_data, out_tag);
    else n_pass++;
    tick();
    n_checks++;
    if (out_vld !== 1'b0 || busy !== 1'b0)
      $display("FAIL arst_drain: vld=%b busy=%b want 0/0", out_vld, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_iu_mult_pipe_fpga
`default_nettype wire
